// File: rtl/hdmi_src_switch_ctl_pkg.sv
// Shared encodings for the HDMI source-switch controller: FSM states and
// source-select values.
package hdmi_ctl_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_VS   = 3'd1;
    localparam logic [2:0] PLL_RST   = 3'd2;
    localparam logic [2:0] WAIT_LOCK = 3'd3;
    localparam logic [2:0] SETTLE    = 3'd4;

    localparam logic SRC_VGA = 1'b0;
    localparam logic SRC_FT  = 1'b1;

endpackage

// File: rtl/hdmi_src_switch_ctl_if.sv
// Video-side control signals of the source-switch controller.
// The master side drives the requests and status; the slave side is the controller.
interface hdmi_src_switch_ctl_if;
    logic sel_req;
    logic vs_in;
    logic pll_locked;
    logic sel_out;
    logic pll_rst;
    logic blank;
    logic busy;
    logic lock_err;

    modport master (
        output sel_req, vs_in, pll_locked,
        input  sel_out, pll_rst, blank, busy, lock_err
    );

    modport slave (
        input  sel_req, vs_in, pll_locked,
        output sel_out, pll_rst, blank, busy, lock_err
    );
endinterface

// File: rtl/hdmi_src_switch_ctl_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/hdmi_src_switch_ctl.sv
// Glitch-free HDMI source switching: moves the source select only on a frame
// boundary, then resets the HDMI PLL and holds blank until lock plus settle frames.
module hdmi_src_switch_ctl
    import hdmi_ctl_pkg::*;
#(
    parameter bit          SEL_INIT      = SRC_VGA,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 1048576,
    parameter int unsigned MAX_RETRY     = 4,
    parameter int unsigned SETTLE_FRAMES = 2,
    parameter int unsigned VS_TIMEOUT    = 2097152,
    parameter bit          VS_POL        = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    hdmi_src_switch_ctl_if.slave io
);
    localparam int unsigned TMR_MAX = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam int FRM_W = $clog2(VS_TIMEOUT + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam int SET_W = $clog2(SETTLE_FRAMES + 1);

    logic             sel_s, lock_s;
    logic             vs_d, vs_edge, vs_tick, vs_any;
    logic [2:0]       state, nxt;
    logic [TMR_W-1:0] tmr;
    logic [FRM_W-1:0] frm;
    logic [RTY_W-1:0] retry;
    logic [SET_W-1:0] frames;
    logic             rst_done, lock_to, settle_done, moving;

    sync2 u_sync_sel  (.clk(clk), .rst_n(reset_n), .d(io.sel_req),    .q(sel_s));
    sync2 u_sync_lock (.clk(clk), .rst_n(reset_n), .d(io.pll_locked), .q(lock_s));

    // With no video the frame timer stands in for vsync so a switch never stalls.
    assign vs_tick     = (frm == FRM_W'(VS_TIMEOUT - 1));
    assign vs_any      = vs_edge | vs_tick;
    assign rst_done    = (tmr == TMR_W'(RST_CYCLES - 1));
    assign lock_to     = (tmr == TMR_W'(LOCK_TIMEOUT - 1));
    assign settle_done = (frames == SET_W'(SETTLE_FRAMES - 1));
    assign moving      = (nxt != state);

    always_comb begin
        nxt = state;
        case (state)
            PLL_RST:   if (rst_done) nxt = WAIT_LOCK;
            WAIT_LOCK: if (lock_s) nxt = SETTLE;
                       else if (lock_to) nxt = PLL_RST;
            SETTLE:    if (!lock_s) nxt = PLL_RST;
                       else if (vs_any && settle_done) nxt = IDLE;
            IDLE:      if (!lock_s) nxt = PLL_RST;
                       else if (sel_s != io.sel_out) nxt = WAIT_VS;
            WAIT_VS:   if (!lock_s) nxt = PLL_RST;
                       else if (sel_s == io.sel_out) nxt = IDLE;
                       else if (vs_any) nxt = PLL_RST;
            default:   nxt = PLL_RST;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= PLL_RST;
            tmr         <= '0;
            frm         <= '0;
            retry       <= '0;
            frames      <= '0;
            vs_d        <= 1'b0;
            vs_edge     <= 1'b0;
            io.sel_out  <= SEL_INIT;
            io.pll_rst  <= 1'b1;
            io.blank    <= 1'b1;
            io.busy     <= 1'b1;
            io.lock_err <= 1'b0;
        end else begin
            state   <= nxt;
            vs_d    <= io.vs_in;
            vs_edge <= VS_POL ? (io.vs_in & ~vs_d) : (~io.vs_in & vs_d);

            if (moving || !(state == PLL_RST || state == WAIT_LOCK)) tmr <= '0;
            else tmr <= tmr + 1'b1;

            if (moving || vs_any) frm <= '0;
            else frm <= frm + 1'b1;

            if (moving) frames <= '0;
            else if (state == SETTLE && vs_any) frames <= frames + 1'b1;

            if (state == WAIT_LOCK && lock_s) begin
                retry       <= '0;
                io.lock_err <= 1'b0;
            end else if (state == WAIT_LOCK && lock_to) begin
                if (retry != RTY_W'(MAX_RETRY)) retry <= retry + 1'b1;
                if (retry >= RTY_W'(MAX_RETRY - 1)) io.lock_err <= 1'b1;
            end

            // Only a frame-boundary exit from WAIT_VS carries lock; lock-loss exits keep the old source.
            if (state == WAIT_VS && nxt == PLL_RST && lock_s) io.sel_out <= sel_s;

            io.pll_rst <= (nxt == PLL_RST);
            io.blank   <= (nxt == PLL_RST) || (nxt == WAIT_LOCK) || (nxt == SETTLE);
            io.busy    <= (nxt != IDLE);
        end
    end
endmodule

// File: doc/hdmi_src_switch_ctl.md
Name: hdmi_src_switch_ctl

Overview:
Sequences glitch-free switching of the HDMI output between the two video sources (VDAC/VGA and FT812) and handles HDMI PLL bring-up and lock-loss recovery.
- Owns the applied source select fed to the HDMI PLL and the output mux.
- Owns the PLL/FIFO reset and a forced-blank flag for the TMDS encoder input.
- Changes source only at a frame boundary. Keeps output blanked until the PLL has relocked and the pipeline has settled for a set number of frames.

Parameters:
- SEL_INIT, 0: source select value applied after reset (0 = VGA, 1 = FT).
- RST_CYCLES, 16: number of clk cycles pll_rst is held high per reset pulse (>=2).
- LOCK_TIMEOUT, 1048576: clk cycles to wait for lock before retrying the reset.
- MAX_RETRY, 4: number of consecutive lock timeouts that sets lock_err.
- SETTLE_FRAMES, 2: active vsync edges seen after lock before unblanking (>=1).
- VS_TIMEOUT, 2097152: clk cycles without a vsync edge that count as one frame boundary.
- VS_POL, 0: vsync active level (0 = active-low, active edge is falling; 1 = active-high, active edge is rising).

Ports:
- clk, in, 1: system clock; all logic runs in this domain.
- reset_n, in, 1: reset, asynchronous, active-low.
- sel_req, in, 1: requested source; passes through a 2-flop synchroniser.
- vs_in, in, 1: vsync of the currently applied source, in the clk domain.
- pll_locked, in, 1: HDMI PLL lock; asynchronous, passes through a 2-flop synchroniser.
- sel_out, out, 1: applied source select (drives vdac2_sel / ft_sel).
- pll_rst, out, 1: reset to HDMI PLL and video/audio FIFOs.
- blank, out, 1: force-black flag; ORed into the encoder blank.
- busy, out, 1: high in every state except IDLE.
- lock_err, out, 1: sticky flag; PLL failed to lock MAX_RETRY times in a row.

Behaviour:
Reset values (reset_n low): state=PLL_RST, sel_out=SEL_INIT, pll_rst=1, blank=1, busy=1, lock_err=0; all counters 0; synchroniser flops 0.

Synchronisers and edge detect:
- sel_s and lock_s lag their inputs by 2 cycles.
- vs_edge is registered: one-cycle pulse on the VS_POL active edge of vs_in, 1 cycle of latency.

Shared timers:
- frame timer: counts clk cycles since the last vs_edge. It clears on vs_edge and on every state entry. When it reaches VS_TIMEOUT-1 it produces a synthetic edge (vs_tick) and wraps to 0.
- vs_any = vs_edge OR vs_tick.

States:
- PLL_RST: pll_rst=1, blank=1. Counts RST_CYCLES cycles, then goes to WAIT_LOCK. pll_rst drops on the first cycle of WAIT_LOCK.
- WAIT_LOCK: pll_rst=0, blank=1.
  - If lock_s=1, go to SETTLE; clear retry_cnt and lock_err.
  - If the timer reaches LOCK_TIMEOUT, go to PLL_RST and increment retry_cnt (saturating). When retry_cnt reaches MAX_RETRY, set lock_err. Retries continue indefinitely.
- SETTLE: blank=1. Count vs_any events. On the SETTLE_FRAMES-th event, go to IDLE.
  - If lock_s falls, go to PLL_RST.
- IDLE: blank=0, busy=0. Priority order:
  1. lock_s==0: go to PLL_RST (lock-loss recovery); blank rises on the next cycle.
  2. sel_s != sel_out: go to WAIT_VS.
- WAIT_VS: blank=0, busy=1.
  - If sel_s == sel_out, go back to IDLE (request withdrawn; no blank, no reset).
  - Else on vs_any: sel_out <= sel_s, blank <= 1, go to PLL_RST. These three updates happen in the same registered cycle.
  - If lock_s falls, go to PLL_RST without changing sel_out.

Request handling outside IDLE/WAIT_VS:
- Changes to sel_req during PLL_RST, WAIT_LOCK or SETTLE are ignored. They are re-evaluated in IDLE, so a request can never be lost.
- If a request toggles and returns during that window, no second switch occurs.

Registers and counters:
- All outputs are registered.
- Counter widths are $clog2(max value + 1).
- No counter wraps except the frame timer.

Timing:
- Minimum sel_req-to-blank latency: 2 (sync) + 1 (IDLE->WAIT_VS) + wait for vs_any + 1 cycle.

Decomposition:
- Package hdmi_ctl_pkg:
  - state encoding enum {IDLE, WAIT_VS, PLL_RST, WAIT_LOCK, SETTLE}
  - source-select encoding constants SRC_VGA=0, SRC_FT=1
- Sub-module: sync2, a 2-flop synchroniser with async active-low reset. Instantiated twice (sel_req, pll_locked).

Test Plan:
- Bring-up: release reset_n, hold pll_locked=0 for 100 cycles then 1. pll_rst high for exactly 16 cycles after release. blank stays 1 until 2 vsync edges after lock. busy=0 and blank=0 after that; sel_out=0.
- Switch: in IDLE, set sel_req=1 and give a vsync falling edge 500 cycles later. sel_out=1 and blank=1 appear together, 1 cycle after the edge is detected. pll_rst pulses for 16 cycles. After relock plus 2 frames, blank=0.
- Withdrawn request: pulse sel_req=1 for 50 cycles with no vsync edge. Returns to IDLE; blank never rises, sel_out stays 0, pll_rst stays 0.
- No video: set sel_req=1 with vs_in tied high and VS_TIMEOUT=1000. Switch occurs 1000 cycles after WAIT_VS entry. SETTLE completes via 2 further timeouts.
- Lock failure: pll_locked held 0, LOCK_TIMEOUT=200, MAX_RETRY=4. pll_rst pulses 4 times and lock_err rises after the 4th timeout. When lock later asserts, lock_err clears on entry to SETTLE.
- Lock loss and mid-operation reset: drop pll_locked in IDLE; blank=1 within 4 cycles, followed by a pll_rst pulse. Separately, assert reset_n low during WAIT_LOCK; all outputs go to reset values immediately (asynchronously).
